ram_loader: RTL



---
 rtl/ram_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// ram_loader: boot-time loader that parses a framed byte stream and writes its payload into RAM,
// holding the CPU in reset until the frame checksum has been verified.
`default_nettype none

module ram_loader #(
   parameter int TIMEOUT = 1000000,
   parameter int TO_W    = 20
) (
   input  logic        clk,
   input  logic        RES,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        RW,
   output logic [15:0] AD,
   output logic [7:0]  D_out,
   output logic        cpu_hold,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_ADDR_LO = 3'd0,
      S_ADDR_HI = 3'd1,
      S_LEN_LO  = 3'd2,
      S_LEN_HI  = 3'd3,
      S_DATA    = 3'd4,
      S_CSUM    = 3'd5,
      S_DONE    = 3'd6,
      S_ERR     = 3'd7
   } state_t;

   localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

   state_t          state_q;
   logic [15:0]     wr_addr_q;
   logic [15:0]     len_q;
   logic [7:0]      sum_q;
   logic [TO_W-1:0] to_q;
   logic            rw_q;
   logic [15:0]     ad_q;
   logic [7:0]      dout_q;
   logic            hold_q;
   logic            done_q;
   logic            err_q;

   logic            in_frame;
   logic            to_expire;
   logic [15:0]     len_full;

   // Only the mid-frame states are subject to the inter-byte timeout.
   assign in_frame  = (state_q != S_ADDR_LO) && (state_q != S_DONE) && (state_q != S_ERR);
   assign to_expire = (TIMEOUT != 0) && in_frame && !rx_valid && ((to_q + 1'b1) == TO_LIM);
   assign len_full  = {rx_data, len_q[7:0]};

   always_ff @(posedge clk) begin
      if (!RES) begin
         state_q   <= S_ADDR_LO;
         wr_addr_q <= '0;
         len_q     <= '0;
         sum_q     <= '0;
         to_q      <= '0;
         rw_q      <= 1'b1;
         ad_q      <= '0;
         dout_q    <= '0;
         hold_q    <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rw_q <= 1'b1;
         if (in_frame && (TIMEOUT != 0)) begin
            to_q <= rx_valid ? '0 : to_q + 1'b1;
         end

         if (to_expire) begin
            // Resync to frame start; anything already written stays in RAM.
            state_q <= S_ADDR_LO;
            sum_q   <= '0;
            len_q   <= '0;
            to_q    <= '0;
         end else if (rx_valid) begin
            case (state_q)
               S_ADDR_LO: begin
                  wr_addr_q[7:0] <= rx_data;
                  sum_q          <= '0;
                  state_q        <= S_ADDR_HI;
               end
               S_ADDR_HI: begin
                  wr_addr_q[15:8] <= rx_data;
                  state_q         <= S_LEN_LO;
               end
               S_LEN_LO: begin
                  len_q   <= {8'h00, rx_data};
                  state_q <= S_LEN_HI;
               end
               S_LEN_HI: begin
                  len_q   <= len_full;
                  state_q <= (len_full == 16'd0) ? S_CSUM : S_DATA;
               end
               S_DATA: begin
                  rw_q      <= 1'b0;
                  ad_q      <= wr_addr_q;
                  dout_q    <= rx_data;
                  wr_addr_q <= wr_addr_q + 16'd1;
                  sum_q     <= sum_q + rx_data;
                  len_q     <= len_q - 16'd1;
                  if (len_q == 16'd1) begin
                     state_q <= S_CSUM;
                  end
               end
               S_CSUM: begin
                  if (rx_data == sum_q) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     hold_q  <= 1'b0;
                  end else begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign RW       = rw_q;
   assign AD       = ad_q;
   assign D_out    = dout_q;
   assign cpu_hold = hold_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

`default_nettype wire
